// File: rtl/ram_block_reader.sv
// ram_block_reader
//   Read-side engine for the capture RAM. A start pulse reads word_count
//   words from base_addr (wrapping at the top of the RAM) through the
//   1-cycle-latency fabric port and streams them as one SOP/EOP-framed
//   valid/ready packet. A 2-entry output FIFO absorbs the read latency so
//   the stream runs at 1 word/clk while out_ready stays high.
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start               begin a packet (sampled only when idle)
//   base_addr           first word address, latched on accepted start
//   word_count          words to read (0..2**ADDR_W), latched on accepted start
//   busy, done          busy from accepted start through the done pulse
//   ram_*               RAM fabric read port (chipselect marks an issued read)
//   out_data/valid/sop/eop/ready  output stream; transfer = valid & ready
module ram_block_reader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     word_count,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   ram_address,
   output logic                ram_chipselect,
   output logic                ram_clken,
   output logic                ram_write,
   output logic [DATA_W/8-1:0] ram_byteenable,
   input  logic [DATA_W-1:0]   ram_readdata,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   output logic                out_sop,
   output logic                out_eop,
   input  logic                out_ready
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   state_t              state_q;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W:0]     count_q;
   logic [ADDR_W:0]     issue_cnt_q;
   logic                inflight_q;
   logic                pend_sop_q;
   logic                pend_eop_q;
   logic [1:0]          fifo_cnt_q;
   logic [DATA_W-1:0]   head_data_q;
   logic                head_sop_q;
   logic                head_eop_q;
   logic [DATA_W-1:0]   tail_data_q;
   logic                tail_sop_q;
   logic                tail_eop_q;

   logic                pop;
   logic                push;
   logic                issue;
   logic                last_issue;
   logic [1:0]          occ_d;

   assign out_valid = (fifo_cnt_q != 2'd0);
   assign pop       = out_valid & out_ready;
   assign push      = inflight_q;

   // Words that will sit in the FIFO after this edge without a new read;
   // issuing only while this is below 2 makes overflow impossible.
   assign occ_d      = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
   assign issue      = (state_q == S_READ) && (occ_d < 2'd2);
   assign last_issue = issue && (issue_cnt_q == count_q - CNT_ONE);

   assign ram_chipselect = issue;
   assign ram_address    = base_q + issue_cnt_q[ADDR_W-1:0];
   assign ram_clken      = 1'b1;
   assign ram_write      = 1'b0;
   assign ram_byteenable = '1;

   assign out_data = head_data_q;
   assign out_sop  = head_sop_q & out_valid;
   assign out_eop  = head_eop_q & out_valid;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         count_q     <= '0;
         issue_cnt_q <= '0;
         inflight_q  <= 1'b0;
         pend_sop_q  <= 1'b0;
         pend_eop_q  <= 1'b0;
         fifo_cnt_q  <= '0;
         head_data_q <= '0;
         head_sop_q  <= 1'b0;
         head_eop_q  <= 1'b0;
         tail_data_q <= '0;
         tail_sop_q  <= 1'b0;
         tail_eop_q  <= 1'b0;
      end else begin
         // Tags travel with the read so they line up with ram_readdata.
         inflight_q <= issue;
         if (issue) begin
            pend_sop_q  <= (issue_cnt_q == '0);
            pend_eop_q  <= last_issue;
            issue_cnt_q <= issue_cnt_q + CNT_ONE;
         end

         case ({push, pop})
            2'b10: begin
               if (fifo_cnt_q == 2'd0) begin
                  head_data_q <= ram_readdata;
                  head_sop_q  <= pend_sop_q;
                  head_eop_q  <= pend_eop_q;
               end else begin
                  tail_data_q <= ram_readdata;
                  tail_sop_q  <= pend_sop_q;
                  tail_eop_q  <= pend_eop_q;
               end
               fifo_cnt_q <= fifo_cnt_q + 2'd1;
            end
            2'b01: begin
               // With one entry the head copy is stale but out_valid drops.
               head_data_q <= tail_data_q;
               head_sop_q  <= tail_sop_q;
               head_eop_q  <= tail_eop_q;
               fifo_cnt_q  <= fifo_cnt_q - 2'd1;
            end
            2'b11: begin
               if (fifo_cnt_q == 2'd1) begin
                  head_data_q <= ram_readdata;
                  head_sop_q  <= pend_sop_q;
                  head_eop_q  <= pend_eop_q;
               end else begin
                  head_data_q <= tail_data_q;
                  head_sop_q  <= tail_sop_q;
                  head_eop_q  <= tail_eop_q;
                  tail_data_q <= ram_readdata;
                  tail_sop_q  <= pend_sop_q;
                  tail_eop_q  <= pend_eop_q;
               end
            end
            default: ;
         endcase

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_q      <= base_addr;
                  count_q     <= word_count;
                  issue_cnt_q <= '0;
                  state_q     <= (word_count == '0) ? S_DONE : S_READ;
               end
            end
            S_READ: begin
               if (last_issue) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (pop && head_eop_q) state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
